// File: rtl/SOPHON_PKG.sv
// Shared LSU request/response payload types.
package SOPHON_PKG;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [3:0]  amo;
        logic [1:0]  size;
    } lsu_req_t;

    typedef struct packed {
        logic        ack;
        logic        error;
        logic [31:0] rdata;
    } lsu_ack_t;

endpackage

// File: rtl/lsu_mbox_slv.sv
// LSU-side mailbox target: TX FIFO (core -> consumer), RX FIFO (producer -> core),
// status and interrupt-enable registers with a single-cycle registered response.
module lsu_mbox_slv
    import SOPHON_PKG::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DW    = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  lsu_req_t      lsu_req_i,
    output lsu_ack_t      lsu_ack_o,
    output logic          tx_valid_o,
    input  logic          tx_ready_i,
    output logic [DW-1:0] tx_data_o,
    input  logic          rx_valid_i,
    output logic          rx_ready_o,
    input  logic [DW-1:0] rx_data_i,
    output logic          irq_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] A_TXDATA = 2'd0;
    localparam logic [1:0] A_RXDATA = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_IRQEN  = 2'd3;

    logic [DW-1:0] tx_mem_q [DEPTH];
    logic [DW-1:0] tx_mem_d [DEPTH];
    logic [DW-1:0] rx_mem_q [DEPTH];
    logic [DW-1:0] rx_mem_d [DEPTH];
    logic [AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic          ack_q, ack_d, err_q, err_d, irq_q, irq_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [1:0]    irq_en_q, irq_en_d;

    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          accept, req_err, lsu_tx_push, lsu_rx_pop, ext_tx_pop, ext_rx_push;
    logic [1:0]    sel;
    logic [31:0]   status;
    logic          unused_bits;

    function automatic logic [3:0] sat4(input logic [CW-1:0] c);
        return (32'(c) > 32'd15) ? 4'hF : 4'(c);
    endfunction

    assign tx_full  = (tx_cnt_q == CW'(DEPTH));
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == CW'(DEPTH));
    assign rx_empty = (rx_cnt_q == '0);

    assign tx_valid_o = !tx_empty;
    assign tx_data_o  = tx_mem_q[tx_rptr_q];
    assign rx_ready_o = !rx_full;
    assign irq_o      = irq_q;

    assign lsu_ack_o.ack   = ack_q;
    assign lsu_ack_o.error = err_q;
    assign lsu_ack_o.rdata = rdata_q;

    assign status      = {20'd0, sat4(rx_cnt_q), sat4(tx_cnt_q), rx_empty, rx_full, tx_empty, tx_full};
    assign unused_bits = ^{lsu_req_i.addr[31:4], lsu_req_i.size};

    // Request decode; every error condition is judged on pre-edge FIFO state.
    always_comb begin
        sel     = lsu_req_i.addr[3:2];
        accept  = lsu_req_i.req && !ack_q;
        req_err = (lsu_req_i.amo != 4'd0) || (lsu_req_i.addr[1:0] != 2'd0)
               || (lsu_req_i.we && (sel == A_TXDATA) && ((lsu_req_i.strb != 4'hF) || tx_full))
               || (!lsu_req_i.we && (sel == A_RXDATA) && rx_empty);
        lsu_tx_push = accept && !req_err && lsu_req_i.we && (sel == A_TXDATA);
        lsu_rx_pop  = accept && !req_err && !lsu_req_i.we && (sel == A_RXDATA);
        ext_tx_pop  = !tx_empty && tx_ready_i;
        ext_rx_push = !rx_full && rx_valid_i;
    end

    // Next-state: response, registers and both FIFOs.
    always_comb begin
        ack_d     = accept;
        err_d     = accept && req_err;
        rdata_d   = 32'd0;
        irq_en_d  = irq_en_q;
        tx_mem_d  = tx_mem_q;
        rx_mem_d  = rx_mem_q;
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        tx_cnt_d  = tx_cnt_q;
        rx_cnt_d  = rx_cnt_q;
        irq_d     = (irq_en_q[0] && !rx_empty) || (irq_en_q[1] && tx_empty);

        if (accept && !req_err && !lsu_req_i.we) begin
            case (sel)
                A_RXDATA: rdata_d = 32'(rx_mem_q[rx_rptr_q]);
                A_STATUS: rdata_d = status;
                A_IRQEN:  rdata_d = {30'd0, irq_en_q};
                default:  rdata_d = 32'd0;
            endcase
        end
        if (accept && !req_err && lsu_req_i.we && (sel == A_IRQEN)) begin
            irq_en_d = lsu_req_i.wdata[1:0];
        end

        if (lsu_tx_push) begin
            tx_mem_d[tx_wptr_q] = DW'(lsu_req_i.wdata);
            tx_wptr_d           = tx_wptr_q + AW'(1);
        end
        if (ext_tx_pop) begin
            tx_rptr_d = tx_rptr_q + AW'(1);
        end
        case ({lsu_tx_push, ext_tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase

        if (ext_rx_push) begin
            rx_mem_d[rx_wptr_q] = rx_data_i;
            rx_wptr_d           = rx_wptr_q + AW'(1);
        end
        if (lsu_rx_pop) begin
            rx_rptr_d = rx_rptr_q + AW'(1);
        end
        case ({ext_rx_push, lsu_rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 32'd0;
            irq_q     <= 1'b0;
            irq_en_q  <= 2'd0;
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                tx_mem_q[i] <= '0;
                rx_mem_q[i] <= '0;
            end
        end else begin
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
            irq_en_q  <= irq_en_d;
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_mem_q  <= tx_mem_d;
            rx_mem_q  <= rx_mem_d;
        end
    end

endmodule

// File: tb/tb_lsu_mbox_slv.sv
// Directed plus randomized bench for lsu_mbox_slv against a queue-based mailbox model.
module tb_lsu_mbox_slv;
    import SOPHON_PKG::*;

    localparam int unsigned DEPTH = 8;

    logic        clk, rst_n;
    lsu_req_t    req;
    lsu_ack_t    ack;
    logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;
    logic [31:0] tx_data, rx_data;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    logic [1:0]  m_irq_en;

    lsu_mbox_slv #(.DEPTH(DEPTH), .DW(32)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .lsu_req_i  (req),
        .lsu_ack_o  (ack),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .tx_data_o  (tx_data),
        .rx_valid_i (rx_valid),
        .rx_ready_o (rx_ready),
        .rx_data_i  (rx_data),
        .irq_o      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] m_status();
        int t;
        int r;
        logic [31:0] s;
        t = tx_q.size();
        r = rx_q.size();
        s = 32'd0;
        s[0]    = (t == DEPTH);
        s[1]    = (t == 0);
        s[2]    = (r == DEPTH);
        s[3]    = (r == 0);
        s[7:4]  = 4'((t > 15) ? 15 : t);
        s[11:8] = 4'((r > 15) ? 15 : r);
        return s;
    endfunction

    function automatic logic m_irq();
        return (m_irq_en[0] && rx_q.size() != 0) || (m_irq_en[1] && tx_q.size() == 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " idle ack"},   32'(ack.ack), 32'd0);
        chk({tag, " idle err"},   32'(ack.error), 32'd0);
        chk({tag, " idle rdata"}, ack.rdata, 32'd0);
        chk({tag, " tx_valid"},   32'(tx_valid), 32'(tx_q.size() != 0));
        if (tx_q.size() != 0) chk({tag, " tx_data"}, tx_data, tx_q[0]);
        chk({tag, " rx_ready"},   32'(rx_ready), 32'(rx_q.size() != DEPTH));
        chk({tag, " irq"},        32'(irq), 32'(m_irq()));
    endtask

    // One LSU access (plus optional same-cycle external traffic); ends at an idle negedge.
    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb, input logic [3:0] amo,
                        input logic txr, input logic rxv, input logic [31:0] rxd,
                        output logic err_o, output logic [31:0] rd_o);
        logic [1:0]  sel;
        logic        e;
        logic [31:0] exp_rd;
        logic        ext_pop, ext_push;
        sel = addr[3:2];
        e = (amo != 4'd0) || (addr[1:0] != 2'd0)
         || (we && sel == 2'd0 && (strb != 4'hF || tx_q.size() == DEPTH))
         || (!we && sel == 2'd1 && rx_q.size() == 0);
        exp_rd = 32'd0;
        if (!e && !we) begin
            if (sel == 2'd1)      exp_rd = rx_q[0];
            else if (sel == 2'd2) exp_rd = m_status();
            else if (sel == 2'd3) exp_rd = {30'd0, m_irq_en};
        end
        ext_pop  = txr && tx_q.size() != 0;
        ext_push = rxv && rx_q.size() < DEPTH;

        req.req = 1'b1; req.we = we; req.addr = addr; req.wdata = wdata;
        req.strb = strb; req.amo = amo; req.size = 2'd2;
        tx_ready = txr; rx_valid = rxv; rx_data = rxd;
        @(posedge clk);
        @(negedge clk);
        chk({tag, " ack"},   32'(ack.ack), 32'd1);
        chk({tag, " err"},   32'(ack.error), 32'(e));
        chk({tag, " rdata"}, ack.rdata, exp_rd);
        err_o = ack.error;
        rd_o  = ack.rdata;

        if (ext_pop) void'(tx_q.pop_front());
        if (!e) begin
            if (we && sel == 2'd0) tx_q.push_back(wdata);
            if (!we && sel == 2'd1) void'(rx_q.pop_front());
            if (we && sel == 2'd3) m_irq_en = wdata[1:0];
        end
        if (ext_push) rx_q.push_back(rxd);

        req.req = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
        @(negedge clk);
        chk_idle(tag);
    endtask

    // External-only traffic for one cycle, then a quiet cycle so irq has settled.
    task automatic ext_step(input string tag, input logic txr, input logic rxv, input logic [31:0] rxd);
        logic ext_pop, ext_push;
        ext_pop  = txr && tx_q.size() != 0;
        ext_push = rxv && rx_q.size() < DEPTH;
        tx_ready = txr; rx_valid = rxv; rx_data = rxd;
        @(posedge clk);
        @(negedge clk);
        tx_ready = 1'b0; rx_valid = 1'b0;
        if (ext_pop) void'(tx_q.pop_front());
        if (ext_push) rx_q.push_back(rxd);
        @(negedge clk);
        chk_idle(tag);
    endtask

    initial begin
        logic        e;
        logic [31:0] rd;
        int          acks;

        req = '0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 32'd0;
        m_irq_en = 2'd0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state and empty status.
        chk_idle("reset");
        xact("st0", 1'b0, 32'h8, 32'd0, 4'hF, 4'd0, 1'b0, 1'b0, 32'd0, e, rd);
        chk("st0 const", rd, 32'h0000_000A);

        // Single TX push.
        xact("tx1", 1'b1, 32'h0, 32'hDEAD_BEEF, 4'hF, 4'd0, 1'b0, 1'b0, 32'd0, e, rd);
        chk("tx1 err const", 32'(e), 32'd0);
        chk("tx1 valid const", 32'(tx_valid), 32'd1);
        chk("tx1 data const", tx_data, 32'hDEAD_BEEF);
        xact("st1", 1'b0, 32'h8, 32'd0, 4'hF, 4'd0, 1'b0, 1'b0, 32'd0, e, rd);
        chk("st1 const", rd, 32'h0000_0018);
        ext_step("drain0", 1'b1, 1'b0, 32'd0);

        // Fill TX, overflow errors, then drain in order.
        for (int i = 1; i <= 8; i++)
            xact("fill", 1'b1, 32'h0, 32'(i), 4'hF, 4'd0, 1'b0, 1'b0, 32'd0, e, rd);
        xact("ovf", 1'b1, 32'h0, 32'd9, 4'hF, 4'd0, 1'b0, 1'b0, 32'd0, e, rd);
        chk("ovf err const", 32'(e), 32'd1);
        xact("stf", 1'b0, 32'h8, 32'd0, 4'hF, 4'd0, 1'b0, 1'b0, 32'd0, e, rd);
        chk("stf const", rd, 32'h0000_0089);
        for (int i = 1; i <= 8; i++) begin
            chk("drain order", tx_data, 32'(i));
            ext_step("drain", 1'b1, 1'b0, 32'd0);
        end
        chk("drain empty const", 32'(tx_valid), 32'd0);

        // RX path with interrupt on not-empty.
        ext_step("rxp1", 1'b0, 1'b1, 32'hA5);
        ext_step("rxp2", 1'b0, 1'b1, 32'h5A);
        xact("ien", 1'b1, 32'hC, 32'd1, 4'hF, 4'd0, 1'b0, 1'b0, 32'd0, e, rd);
        chk("irq on const", 32'(irq), 32'd1);
        xact("rx1", 1'b0, 32'h4, 32'd0, 4'hF, 4'd0, 1'b0, 1'b0, 32'd0, e, rd);
        chk("rx1 const", rd, 32'hA5);
        xact("rx2", 1'b0, 32'h4, 32'd0, 4'hF, 4'd0, 1'b0, 1'b0, 32'd0, e, rd);
        chk("rx2 const", rd, 32'h5A);
        chk("irq off const", 32'(irq), 32'd0);
        xact("rx3", 1'b0, 32'h4, 32'd0, 4'hF, 4'd0, 1'b0, 1'b0, 32'd0, e, rd);
        chk("rx3 err const", 32'(e), 32'd1);
        chk("rx3 rdata const", rd, 32'd0);

        // Error responses leave state untouched.
        xact("amo", 1'b1, 32'h0, 32'h1234, 4'hF, 4'd1, 1'b0, 1'b0, 32'd0, e, rd);
        chk("amo err const", 32'(e), 32'd1);
        chk("amo txcnt const", 32'(tx_valid), 32'd0);
        xact("mis", 1'b0, 32'h9, 32'd0, 4'hF, 4'd0, 1'b0, 1'b0, 32'd0, e, rd);
        chk("mis err const", 32'(e), 32'd1);
        xact("strb", 1'b1, 32'h0, 32'h77, 4'h3, 4'd0, 1'b0, 1'b0, 32'd0, e, rd);
        chk("strb err const", 32'(e), 32'd1);

        // Full TX with a same-cycle external pop still rejects the push.
        for (int i = 0; i < 8; i++)
            xact("fill2", 1'b1, 32'h0, 32'h100 + 32'(i), 4'hF, 4'd0, 1'b0, 1'b0, 32'd0, e, rd);
        xact("fullpop", 1'b1, 32'h0, 32'hBAD, 4'hF, 4'd0, 1'b1, 1'b0, 32'd0, e, rd);
        chk("fullpop err const", 32'(e), 32'd1);

        // Request held across ack: one ack every two cycles.
        req.req = 1'b1; req.we = 1'b0; req.addr = 32'h8; req.strb = 4'hF; req.amo = 4'd0;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("b2b ack", 32'(ack.ack), 32'((i % 2) == 0));
            if (ack.ack) acks++;
        end
        req.req = 1'b0;
        chk("b2b count", 32'(acks), 32'd4);
        @(negedge clk);
        chk_idle("b2b");

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            logic [3:0]  s, am;
            a = $urandom;
            a[1:0] = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            s  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            am = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            xact("rnd", 1'($urandom), a, $urandom, s, am,
                 1'($urandom_range(0, 2) == 0), 1'($urandom), $urandom, e, rd);
        end

        // Reset while a request is pending.
        for (int i = 0; i < 3; i++)
            xact("pre", 1'b1, 32'h0, 32'h55 + 32'(i), 4'hF, 4'd0, 1'b0, 1'b1, 32'h66 + 32'(i), e, rd);
        req.req = 1'b1; req.we = 1'b1; req.addr = 32'h0; req.wdata = 32'hFEED; req.strb = 4'hF;
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst ack", 32'(ack.ack), 32'd0);
        req.req = 1'b0;
        rst_n = 1'b1;
        tx_q.delete(); rx_q.delete(); m_irq_en = 2'd0;
        @(negedge clk);
        chk_idle("rstmid");
        xact("strst", 1'b0, 32'h8, 32'd0, 4'hF, 4'd0, 1'b0, 1'b0, 32'd0, e, rd);
        chk("strst const", rd, 32'h0000_000A);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
